// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU: opmodes, controller states,
// error flag positions and the CRC3 step used by every CRC3 instance.
package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FLAG = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Bit positions inside res_err_flags = {ERR_DATA, ERR_CRC, ERR_OP}
    localparam int ERR_DATA_BIT = 2;
    localparam int ERR_CRC_BIT  = 1;
    localparam int ERR_OP_BIT   = 0;

    // x^3 + x + 1 without the implicit x^3 term
    localparam logic [2:0] CRC3_POLY = 3'b011;

    function automatic logic op_is_valid(input logic [2:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic bit_in);
        logic fb;
        fb = crc[2] ^ bit_in;
        return {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
    endfunction

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC3 over a 37-bit word, MSB first, zero init, no final XOR.
module mtm_alu_crc3
    import mtm_alu_pkg::*;
(
    input  logic [36:0] data,
    output logic [2:0]  crc
);

    // Unrolled serial LFSR across all 37 bits
    always_comb begin
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            crc = crc3_step(crc, data[i]);
        end
    end

endmodule

// File: rtl/mtm_alu_ctrl.sv
// MTM ALU sequencing controller: command handshake, core drive, flag and
// CRC3 generation, response handshake and saturating statistics counters.
module mtm_alu_ctrl
    import mtm_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_err,
    output logic [DATA_W-1:0] res_c,
    output logic [3:0]        res_flags,
    output logic [2:0]        res_crc,
    output logic [2:0]        res_err_flags,
    output logic [CNT_W-1:0]  cnt_ok,
    output logic [CNT_W-1:0]  cnt_err
);

    state_t            state_r, state_next_s;
    logic              cmd_ready_r, res_valid_r, res_err_r;
    logic [DATA_W-1:0] alu_a_r, alu_b_r, res_c_r;
    logic [2:0]        alu_op_r, res_crc_r, res_err_flags_r;
    logic [3:0]        res_flags_r, flags_s;
    logic [CNT_W-1:0]  cnt_ok_r, cnt_err_r;
    logic [2:0]        err_flags_s, crc_s;
    logic [DATA_W:0]   sum_s;
    logic              carry_s, ovf_s, accept_s, res_hs_s;

    assign accept_s = cmd_valid && cmd_ready_r;
    assign res_hs_s = res_valid_r && res_ready;

    // Error classification at accept time, highest priority first
    always_comb begin
        err_flags_s = 3'b000;
        if (cmd_err[1]) begin
            err_flags_s[ERR_DATA_BIT] = 1'b1;
        end else if (cmd_err[0]) begin
            err_flags_s[ERR_CRC_BIT] = 1'b1;
        end else if (!op_is_valid(cmd_op)) begin
            err_flags_s[ERR_OP_BIT] = 1'b1;
        end else begin
            err_flags_s = 3'b000;
        end
    end

    // Status flags from the registered operands and the core result
    always_comb begin
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        sum_s   = {1'b0, alu_a_r} + {1'b0, alu_b_r};
        case (alu_op_r)
            OP_ADD: begin
                carry_s = sum_s[DATA_W];
                ovf_s   = (alu_a_r[DATA_W-1] == alu_b_r[DATA_W-1]) &&
                          (alu_c[DATA_W-1] != alu_a_r[DATA_W-1]);
            end
            OP_SUB: begin
                carry_s = (alu_a_r < alu_b_r);
                ovf_s   = (alu_a_r[DATA_W-1] != alu_b_r[DATA_W-1]) &&
                          (alu_c[DATA_W-1] != alu_a_r[DATA_W-1]);
            end
            default: begin
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
        flags_s = {carry_s, ovf_s, (alu_c == {DATA_W{1'b0}}), alu_c[DATA_W-1]};
    end

    mtm_alu_crc3 u_crc3 (
        .data ({res_c_r, 1'b0, res_flags_r}),
        .crc  (crc_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; errored commands skip straight to the response
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = (err_flags_s != 3'b000) ? ST_RESP : ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_FLAG;
            ST_FLAG: state_next_s = ST_RESP;
            ST_RESP: begin
                if (res_hs_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Registered handshakes, datapath capture and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_r     <= 1'b1;
            res_valid_r     <= 1'b0;
            alu_a_r         <= {DATA_W{1'b0}};
            alu_b_r         <= {DATA_W{1'b0}};
            alu_op_r        <= 3'b000;
            res_c_r         <= {DATA_W{1'b0}};
            res_flags_r     <= 4'b0000;
            res_crc_r       <= 3'b000;
            res_err_r       <= 1'b0;
            res_err_flags_r <= 3'b000;
            cnt_ok_r        <= {CNT_W{1'b0}};
            cnt_err_r       <= {CNT_W{1'b0}};
        end else begin
            cmd_ready_r <= (state_next_s == ST_IDLE);
            res_valid_r <= (state_next_s == ST_RESP);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (err_flags_s != 3'b000)) begin
                        res_err_r       <= 1'b1;
                        res_err_flags_r <= err_flags_s;
                        res_c_r         <= {DATA_W{1'b0}};
                        res_flags_r     <= 4'b0000;
                        res_crc_r       <= 3'b000;
                    end else if (accept_s) begin
                        alu_a_r         <= cmd_a;
                        alu_b_r         <= cmd_b;
                        alu_op_r        <= cmd_op;
                        res_err_r       <= 1'b0;
                        res_err_flags_r <= 3'b000;
                    end
                end
                ST_EXEC: begin
                    res_c_r     <= alu_c;
                    res_flags_r <= flags_s;
                end
                ST_FLAG: res_crc_r <= crc_s;
                ST_RESP: begin
                    if (res_hs_s && res_err_r && (cnt_err_r != {CNT_W{1'b1}})) begin
                        cnt_err_r <= cnt_err_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (res_hs_s && !res_err_r && (cnt_ok_r != {CNT_W{1'b1}})) begin
                        cnt_ok_r <= cnt_ok_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_r;
    assign res_valid     = res_valid_r;
    assign alu_a         = alu_a_r;
    assign alu_b         = alu_b_r;
    assign alu_op        = alu_op_r;
    assign res_err       = res_err_r;
    assign res_c         = res_c_r;
    assign res_flags     = res_flags_r;
    assign res_crc       = res_crc_r;
    assign res_err_flags = res_err_flags_r;
    assign cnt_ok        = cnt_ok_r;
    assign cnt_err       = cnt_err_r;

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Self-checking bench for mtm_alu_ctrl: directed plan cases plus random
// commands compared against an arithmetic reference model.
module tb_mtm_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_err;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op;
    logic        res_valid, res_ready, res_err;
    logic [31:0] res_c;
    logic [3:0]  res_flags;
    logic [2:0]  res_crc, res_err_flags;
    logic [15:0] cnt_ok, cnt_err;

    int checks = 0;
    int failures = 0;
    int exp_ok = 0;
    int exp_err = 0;
    logic [31:0] obs_c;
    logic [3:0]  obs_flags;
    logic [2:0]  obs_crc, obs_eflags;

    always #5 clk = ~clk;

    mtm_alu_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_err(cmd_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_err(res_err),
        .res_c(res_c), .res_flags(res_flags), .res_crc(res_crc),
        .res_err_flags(res_err_flags), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    // Stand-in for the combinational ALU core
    always_comb begin
        case (alu_op)
            3'b000:  alu_c = alu_a & alu_b;
            3'b001:  alu_c = alu_a | alu_b;
            3'b100:  alu_c = alu_a + alu_b;
            3'b101:  alu_c = alu_a - alu_b;
            default: alu_c = 32'h0000_0000;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC3 as the remainder of polynomial long division of word * x^3
    function automatic logic [2:0] ref_crc(input logic [36:0] word);
        logic [39:0] r;
        r = {word, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        end
        return r[2:0];
    endfunction

    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                             input logic [1:0] err, output logic e, output logic [2:0] ef,
                             output logic [31:0] c, output logic [3:0] fl, output logic [2:0] crc);
        longint sa, sb, s;
        logic [63:0] ua, ub;
        logic cy, ov;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = {32'h0, a}; ub = {32'h0, b};
        cy = 1'b0; ov = 1'b0; c = 32'h0; fl = 4'h0; crc = 3'h0;
        e = 1'b1;
        if (err[1]) ef = 3'b100;
        else if (err[0]) ef = 3'b010;
        else if (!(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5)) ef = 3'b001;
        else begin
            e = 1'b0; ef = 3'b000;
            if (op == 3'd0) c = a & b;
            else if (op == 3'd1) c = a | b;
            else if (op == 3'd4) begin
                c = a + b; cy = (ua + ub) > 64'hFFFF_FFFF;
                s = sa + sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end else begin
                c = a - b; cy = ua < ub;
                s = sa - sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            fl = {cy, ov, c == 32'h0, c[31]};
            crc = ref_crc({c, 1'b0, fl});
        end
    endtask

    // One full command/response exchange; entered and left #1 after a rising edge
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [1:0] err, input int hold);
        logic e; logic [2:0] ef, crc; logic [31:0] c, prev_a; logic [3:0] fl;
        logic [42:0] snap;
        int lat, wait_n;
        ref_model(a, b, op, err, e, ef, c, fl, crc);
        wait_n = 0;
        while (!cmd_ready && wait_n < 10) begin @(posedge clk); #1; wait_n++; end
        check("cmd_ready_idle", {63'h0, cmd_ready}, 64'h1);
        prev_a = alu_a;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_err = err; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = (hold > 0);
        lat = 1;
        while (!res_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check("latency", 64'(lat), e ? 64'd1 : 64'd3);
        check("res_err", {63'h0, res_err}, {63'h0, e});
        check("res_err_flags", {61'h0, res_err_flags}, {61'h0, ef});
        check("res_c", {32'h0, res_c}, {32'h0, c});
        check("res_flags", {60'h0, res_flags}, {60'h0, fl});
        check("res_crc", {61'h0, res_crc}, {61'h0, crc});
        check("alu_a", {32'h0, alu_a}, {32'h0, e ? prev_a : a});
        obs_c = res_c; obs_flags = res_flags; obs_crc = res_crc; obs_eflags = res_err_flags;
        snap = {res_err, res_err_flags, res_c, res_flags, res_crc};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_stable", {21'h0, res_err, res_err_flags, res_c, res_flags, res_crc}, {21'h0, snap});
            check("hold_backpressure", {62'h0, cmd_ready, res_valid}, 64'h1);
        end
        res_ready = 1'b1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b0;
        if (e) exp_err++; else exp_ok++;
        check("post_hs_ready_valid", {62'h0, cmd_ready, res_valid}, 64'h2);
        check("counters", {32'h0, cnt_ok, cnt_err}, {32'h0, exp_ok[15:0], exp_err[15:0]});
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = 32'h0; cmd_b = 32'h0; cmd_op = 3'h0; cmd_err = 2'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {62'h0, cmd_ready, res_valid}, 64'h2);
        check("reset_res", {24'h0, res_err, res_err_flags, res_c, res_flags, res_crc}, 64'h0);
        check("reset_cnt", {32'h0, cnt_ok, cnt_err}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(32'h0000_0000, 32'h0000_0000, 3'b000, 2'b00, 0);
        check("plan_and_zero", {57'h0, obs_flags, obs_crc}, {57'h0, 4'b0010, 3'b110});
        run_cmd(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 2'b00, 0);
        check("plan_add_carry", {28'h0, obs_c, obs_flags}, {28'h0, 32'h0, 4'b1010});
        run_cmd(32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 2'b00, 1);
        check("plan_add_ovf", {28'h0, obs_c, obs_flags}, {28'h0, 32'h8000_0000, 4'b0101});
        run_cmd(32'h0000_0001, 32'h0000_0002, 3'b101, 2'b00, 0);
        check("plan_sub_borrow", {28'h0, obs_c, obs_flags}, {28'h0, 32'hFFFF_FFFF, 4'b1001});
        run_cmd(32'h8000_0000, 32'h0000_0001, 3'b101, 2'b00, 0);
        check("plan_sub_ovf", {28'h0, obs_c, obs_flags}, {28'h0, 32'h7FFF_FFFF, 4'b0100});
        run_cmd(32'h1234_5678, 32'h0F0F_0F0F, 3'b010, 2'b00, 0);
        check("plan_err_op", {29'h0, obs_c, obs_eflags}, {29'h0, 32'h0, 3'b001});
        run_cmd(32'hDEAD_BEEF, 32'h1, 3'b111, 2'b11, 0);
        check("plan_err_data", {61'h0, obs_eflags}, 64'h4);
        run_cmd(32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b001, 2'b01, 2);
        run_cmd(32'hCAFE_0000, 32'h0000_BABE, 3'b001, 2'b00, 10);

        for (int n = 0; n < 24; n++) begin
            logic [2:0] op;
            logic [1:0] err;
            op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : {1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1))};
            err = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_cmd($urandom, $urandom, op, err, $urandom_range(0, 3));
        end

        // Abort a transaction while in EXEC
        cmd_a = 32'h1; cmd_b = 32'h2; cmd_op = 3'b100; cmd_err = 2'b00; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {62'h0, cmd_ready, res_valid}, 64'h2);
        check("async_reset_res", {24'h0, res_err, res_err_flags, res_c, res_flags, res_crc}, 64'h0);
        check("async_reset_alu", {29'h0, alu_a | alu_b, alu_op}, 64'h0);
        check("async_reset_cnt", {32'h0, cnt_ok, cnt_err}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_ok = 0; exp_err = 0;
        repeat (4) @(posedge clk);
        #1;
        check("no_resp_after_abort", {63'h0, res_valid}, 64'h0);
        run_cmd(32'h0000_0003, 32'h0000_0005, 3'b100, 2'b00, 0);
        check("post_reset_cnt_ok", {48'h0, cnt_ok}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
